// File: rtl/sd_pkg.sv
// Shared constants, FSM state type and error-code helpers for the sudoku puzzle transmitter.
package sd_pkg;

  localparam int unsigned CELLS      = 81;
  localparam int unsigned BLANKS     = 15;
  localparam logic [3:0]  NOSOL_CODE = 4'd10;

  localparam logic [2:0] ErrOk       = 3'd0;
  localparam logic [2:0] ErrMismatch = 3'd1;
  localparam logic [2:0] ErrCount    = 3'd2;
  localparam logic [2:0] ErrProtocol = 3'd3;
  localparam logic [2:0] ErrTimeout  = 3'd4;
  localparam logic [2:0] ErrBlanks   = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StRecv,
    StCheck
  } state_e;

  // Priority rank of an error code; larger wins (3 > 5 > 2 > 1 > 4 > ok).
  function automatic logic [2:0] err_rank(input logic [2:0] code);
    logic [2:0] rank;
    case (code)
      ErrTimeout:  rank = 3'd1;
      ErrMismatch: rank = 3'd2;
      ErrCount:    rank = 3'd3;
      ErrBlanks:   rank = 3'd4;
      ErrProtocol: rank = 3'd5;
      default:     rank = 3'd0;
    endcase
    return rank;
  endfunction

  // Keep the current code unless the new one strictly outranks it.
  function automatic logic [2:0] err_merge(input logic [2:0] cur, input logic [2:0] nxt);
    return (err_rank(nxt) > err_rank(cur)) ? nxt : cur;
  endfunction

endpackage

// File: rtl/sd_cell_mem.sv
// 81 x 4-bit puzzle cell register file: one write port, one read index.
module sd_cell_mem
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic [6:0] waddr_i,
  input  logic [3:0] wdata_i,
  input  logic [6:0] raddr_i,
  output logic [3:0] rdata_o
);

  logic [3:0] mem_q [CELLS];

  // Cell storage; out-of-range writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CELLS; i++) mem_q[i] <= 4'd0;
    end else if (we_i && (waddr_i < 7'(CELLS))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port for the index walked by the transmitter.
  always_comb begin
    rdata_o = (raddr_i < 7'(CELLS)) ? mem_q[raddr_i] : 4'd0;
  end

endmodule

// File: rtl/sd_puzzle_tx.sv
// Sudoku puzzle transmitter: streams 81 stored cells to a solver, then checks its answer
// words against stored expected values. Optional WAIT timeout under SD_TX_TIMEOUT_EN.
module sd_puzzle_tx
  import sd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid_i,
  input  logic [6:0] load_addr_i,
  input  logic [3:0] load_data_i,
  input  logic       exp_valid_i,
  input  logic [3:0] exp_idx_i,
  input  logic [3:0] exp_data_i,
  input  logic       exp_nosol_i,
  input  logic       start_i,
  output logic       in_valid_o,
  output logic [3:0] in_o,
  input  logic       out_valid_i,
  input  logic [3:0] out_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [2:0] err_code_o
);

  localparam logic [6:0] LastCell  = 7'(CELLS - 1);
  localparam logic [3:0] BlankFull = 4'(BLANKS);

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [3:0] blank_q, blank_d;
  logic       blank_ovf_q, blank_ovf_d;
  logic [4:0] word_q, word_d;
  logic       nosol_q, nosol_d;
  logic [2:0] err_q, err_d;
  logic       pass_q, pass_d;
  logic [3:0] exp_q [BLANKS];
  logic [3:0] cell_rd;
  logic [4:0] words_req;
  logic [3:0] word_exp;
  logic       idle;
  logic       timeout_hit;

  assign idle = (state_q == StIdle);

  sd_cell_mem u_cell_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (load_valid_i && idle),
    .waddr_i (load_addr_i),
    .wdata_i (load_data_i),
    .raddr_i (cnt_q),
    .rdata_o (cell_rd)
  );

  // Expected answers; host writes land only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLANKS; i++) exp_q[i] <= 4'd0;
    end else if (exp_valid_i && idle && (exp_idx_i < 4'(BLANKS))) begin
      exp_q[exp_idx_i] <= exp_data_i;
    end
  end

`ifdef SD_TX_TIMEOUT_EN
  localparam int unsigned WaitW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  logic [WaitW-1:0] wait_q, wait_d;

  // Idle cycles spent in WAIT; cleared whenever WAIT is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end

  // Count up only while the solver stays silent in WAIT.
  always_comb begin
    wait_d = '0;
    if ((state_q == StWait) && !out_valid_i) wait_d = wait_q + 1'b1;
  end

  assign timeout_hit = (state_q == StWait) && !out_valid_i &&
                       (wait_q == WaitW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      blank_q     <= '0;
      blank_ovf_q <= 1'b0;
      word_q      <= '0;
      nosol_q     <= 1'b0;
      err_q       <= ErrOk;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blank_q     <= blank_d;
      blank_ovf_q <= blank_ovf_d;
      word_q      <= word_d;
      nosol_q     <= nosol_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StSend;
      StSend:  if (cnt_q == LastCell) state_d = StWait;
      StWait: begin
        if (out_valid_i)      state_d = StRecv;
        else if (timeout_hit) state_d = StCheck;
      end
      StRecv:  if (!out_valid_i) state_d = StCheck;
      StCheck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign words_req = nosol_q ? 5'd1 : 5'(BLANKS);
  assign word_exp  = nosol_q ? NOSOL_CODE :
                     ((word_q < 5'(BLANKS)) ? exp_q[word_q[3:0]] : 4'd0);

  // Datapath next values: cell walk, blank census, answer checking, error latching.
  always_comb begin
    cnt_d       = cnt_q;
    blank_d     = blank_q;
    blank_ovf_d = blank_ovf_q;
    word_d      = word_q;
    nosol_d     = nosol_q;
    err_d       = err_q;
    pass_d      = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          cnt_d       = '0;
          blank_d     = '0;
          blank_ovf_d = 1'b0;
          word_d      = '0;
          nosol_d     = exp_nosol_i;
          err_d       = ErrOk;
          pass_d      = 1'b0;
        end
      end
      StSend: begin
        cnt_d = (cnt_q == LastCell) ? 7'd0 : cnt_q + 7'd1;
        if (cell_rd == 4'd0) begin
          if (blank_q == BlankFull) blank_ovf_d = 1'b1;
          else                      blank_d     = blank_q + 4'd1;
        end
        if (out_valid_i) err_d = err_merge(err_d, ErrProtocol);
        // Census includes the last cell, hence the _d values.
        if ((cnt_q == LastCell) && !nosol_q && ((blank_d != BlankFull) || blank_ovf_d)) begin
          err_d = err_merge(err_d, ErrBlanks);
        end
      end
      StWait, StRecv: begin
        if (out_valid_i) begin
          if (word_q < words_req) begin
            if (out_i != word_exp) err_d = err_merge(err_d, ErrMismatch);
          end else begin
            err_d = err_merge(err_d, ErrCount);
          end
          if (word_q != 5'd31) word_d = word_q + 5'd1;
        end else if (state_q == StRecv) begin
          if (word_q != words_req) err_d = err_merge(err_d, ErrCount);
        end else if (timeout_hit) begin
          err_d = err_merge(err_d, ErrTimeout);
        end
      end
      StCheck: pass_d = (err_q == ErrOk);
      default: ;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    in_valid_o = (state_q == StSend);
    in_o       = (state_q == StSend) ? cell_rd : 4'd0;
    busy_o     = (state_q != StIdle);
    done_o     = (state_q == StCheck);
    pass_o     = (state_q == StCheck) ? (err_q == ErrOk) : pass_q;
    err_code_o = err_q;
  end

endmodule

// File: tb/tb_sd_puzzle_tx.sv
// Directed bench for sd_puzzle_tx: send/answer flows, error codes, priority, reset abort.
module tb_sd_puzzle_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_valid;
  logic [6:0] load_addr;
  logic [3:0] load_data;
  logic       exp_valid;
  logic [3:0] exp_idx;
  logic [3:0] exp_data;
  logic       exp_nosol;
  logic       start;
  logic       in_valid;
  logic [3:0] in_val;
  logic       out_valid;
  logic [3:0] out_val;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_code;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] puz  [81];
  logic [3:0] expv [15];

  always #5 clk = ~clk;

  sd_puzzle_tx #(
    .TIMEOUT_CYC (50)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid_i (load_valid),
    .load_addr_i  (load_addr),
    .load_data_i  (load_data),
    .exp_valid_i  (exp_valid),
    .exp_idx_i    (exp_idx),
    .exp_data_i   (exp_data),
    .exp_nosol_i  (exp_nosol),
    .start_i      (start),
    .in_valid_o   (in_valid),
    .in_o         (in_val),
    .out_valid_i  (out_valid),
    .out_i        (out_val),
    .busy_o       (busy),
    .done_o       (done),
    .pass_o       (pass),
    .err_code_o   (err_code)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference puzzle: cells 1..9 by column, blanks at every 5th cell.
  task automatic set_model(input int nblanks);
    for (int i = 0; i < 81; i++) puz[i] = 4'((i % 9) + 1);
    for (int b = 0; b < nblanks; b++) puz[b * 5] = 4'd0;
    for (int k = 0; k < 15; k++) expv[k] = 4'((k % 9) + 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 81; i++) puz[i] = 4'd0;
    for (int k = 0; k < 15; k++) expv[k] = 4'd0;
  endtask

  task automatic load_puzzle();
    for (int i = 0; i < 81; i++) begin
      @(negedge clk);
      load_valid = 1'b1;
      load_addr  = 7'(i);
      load_data  = puz[i];
    end
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic load_exp();
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      exp_valid = 1'b1;
      exp_idx   = 4'(k);
      exp_data  = expv[k];
    end
    @(negedge clk);
    exp_valid = 1'b0;
  endtask

  task automatic write_cell(input int a, input logic [3:0] d);
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = 7'(a);
    load_data  = d;
    puz[a]     = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Start a transaction and check the 81-cell stream. Optional out_valid pulse at a SEND
  // cycle, reset at a SEND cycle, or ignored host writes/start during SEND.
  task automatic run_send(input int proto_cyc, input int rst_cyc, input bit poke);
    int bad;
    bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 81; i++) begin
      if (i == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        check_eq("rst_in_valid", 32'(in_valid), 32'(0));
        check_eq("rst_busy", 32'(busy), 32'(0));
        check_eq("rst_done", 32'(done), 32'(0));
        return;
      end
      if (in_valid !== 1'b1 || in_val !== puz[i] || busy !== 1'b1) bad++;
      out_valid  = (i == proto_cyc);
      load_valid = poke && (i == 10);
      load_addr  = 7'd0;
      load_data  = 4'd9;
      start      = poke && (i == 20);
      @(negedge clk);
    end
    out_valid  = 1'b0;
    load_valid = 1'b0;
    start      = 1'b0;
    check_eq("send_cells", 32'(bad), 32'(0));
    check_eq("send_end_in_valid", 32'(in_valid), 32'(0));
    check_eq("send_end_in", 32'(in_val), 32'(0));
    check_eq("wait_busy", 32'(busy), 32'(1));
  endtask

  task automatic reply(input int n, input int bad_idx, input logic [3:0] bad_val,
                       input bit nosol_words);
    for (int k = 0; k < n; k++) begin
      out_valid = 1'b1;
      if (nosol_words)       out_val = 4'd10;
      else if (k == bad_idx) out_val = bad_val;
      else                   out_val = expv[k % 15];
      @(negedge clk);
    end
    out_valid = 1'b0;
    out_val   = 4'd0;
  endtask

  task automatic expect_done(input string tag, input logic pass_exp, input logic [2:0] err_exp);
    int t;
    t = 0;
    while (done !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_done"}, 32'(done), 32'(1));
    check_eq({tag, "_pass"}, 32'(pass), 32'(pass_exp));
    check_eq({tag, "_err"}, 32'(err_code), 32'(err_exp));
    @(negedge clk);
    check_eq({tag, "_done_drop"}, 32'(done), 32'(0));
    check_eq({tag, "_idle"}, 32'(busy), 32'(0));
    check_eq({tag, "_pass_hold"}, 32'(pass), 32'(pass_exp));
    check_eq({tag, "_err_hold"}, 32'(err_code), 32'(err_exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int seen;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_addr  = 7'd0;
    load_data  = 4'd0;
    exp_valid  = 1'b0;
    exp_idx    = 4'd0;
    exp_data   = 4'd0;
    exp_nosol  = 1'b0;
    start      = 1'b0;
    out_valid  = 1'b0;
    out_val    = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_in_valid", 32'(in_valid), 32'(0));
    check_eq("reset_in", 32'(in_val), 32'(0));
    check_eq("reset_busy", 32'(busy), 32'(0));
    check_eq("reset_done", 32'(done), 32'(0));
    check_eq("reset_pass", 32'(pass), 32'(0));
    check_eq("reset_err", 32'(err_code), 32'(0));

    // Full matching answer.
    set_model(15);
    load_puzzle();
    load_exp();
    run_send(-1, -1, 1'b0);
    reply(15, -1, 4'd0, 1'b0);
    expect_done("match", 1'b1, 3'd0);

    // Stored puzzle resent; word 7 wrong; writes and start during SEND ignored.
    run_send(-1, -1, 1'b1);
    reply(15, 7, 4'd3, 1'b0);
    expect_done("mismatch", 1'b0, 3'd1);

    // No-solution expectation.
    exp_nosol = 1'b1;
    run_send(-1, -1, 1'b0);
    reply(1, -1, 4'd0, 1'b1);
    expect_done("nosol", 1'b1, 3'd0);
    run_send(-1, -1, 1'b0);
    reply(15, -1, 4'd0, 1'b1);
    expect_done("nosol_count", 1'b0, 3'd2);

    // Short reply with a bad word: count outranks mismatch.
    exp_nosol = 1'b0;
    run_send(-1, -1, 1'b0);
    reply(10, 2, 4'd9, 1'b0);
    expect_done("short", 1'b0, 3'd2);

    // Long reply.
    run_send(-1, -1, 1'b0);
    reply(17, -1, 4'd0, 1'b0);
    expect_done("long", 1'b0, 3'd2);

    // 14 blanks plus a bad word: blanks outrank mismatch.
    write_cell(70, 4'd5);
    run_send(-1, -1, 1'b0);
    reply(15, 3, 4'd1, 1'b0);
    expect_done("blanks", 1'b0, 3'd5);

    // out_valid during SEND with bad blanks and short reply: protocol wins.
    run_send(40, -1, 1'b0);
    reply(10, -1, 4'd0, 1'b0);
    expect_done("protocol", 1'b0, 3'd3);

    // Silent solver.
    write_cell(70, 4'd0);
    run_send(-1, -1, 1'b0);
`ifdef SD_TX_TIMEOUT_EN
    t = 0;
    while (done !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("timeout_cycles", 32'(t), 32'(50));
    check_eq("timeout_err", 32'(err_code), 32'(4));
    check_eq("timeout_pass", 32'(pass), 32'(0));
`else
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    check_eq("no_timeout_done", 32'(seen), 32'(0));
    check_eq("no_timeout_busy", 32'(busy), 32'(1));
`endif
    do_reset();

    // Reset at SEND cycle 30 aborts without done; storage cleared.
    set_model(15);
    load_puzzle();
    load_exp();
    run_send(-1, 30, 1'b0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    rst_n = 1'b1;
    check_eq("abort_no_done", 32'(seen), 32'(0));
    check_eq("abort_idle", 32'(busy), 32'(0));
    for (int i = 0; i < 81; i++) puz[i] = 4'd0;
    run_send(-1, -1, 1'b0);
    do_reset();
    set_model(15);
    load_puzzle();
    load_exp();
    run_send(-1, -1, 1'b0);
    reply(15, -1, 4'd0, 1'b0);
    expect_done("after_abort", 1'b1, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_puzzle_tx.md
SD_PUZZLE_TX -- requirements
Module: sd_puzzle_tx

Interface
REQ-001 Parameter: TIMEOUT_CYC, 2000, max cycles from last sent cell to first solver answer word.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 load_valid  input  1  host writes one puzzle cell this cycle.
REQ-005 load_addr  input  7  cell index 0..80, row-major (y*9+x).
REQ-006 load_data  input  4  cell value 0..9; 0 = blank.
REQ-007 exp_valid  input  1  host writes one expected answer this cycle.
REQ-008 exp_idx  input  4  answer index 0..14, blank order row-major.
REQ-009 exp_data  input  4  expected value 1..9.
REQ-010 exp_nosol  input  1  level, sampled at start; 1 = expect the no-solution code 10.
REQ-011 start  input  1  one-cycle pulse; begins a transaction.
REQ-012 in_valid  output  1  solver-side cell strobe.
REQ-013 in  output  4  solver-side cell value.
REQ-014 out_valid  input  1  solver answer strobe.
REQ-015 out  input  4  solver answer value.
REQ-016 busy  output  1  transaction in progress.
REQ-017 done  output  1  one-cycle pulse at transaction end.
REQ-018 pass  output  1  result valid with done; held until next start.
REQ-019 err_code  output  3  0 ok, 1 mismatch, 2 count, 3 protocol, 4 timeout, 5 bad blanks; held until next start.

Function
REQ-020 FSM states: IDLE, SEND, WAIT, RECV, CHECK; reset state IDLE.
REQ-021 IDLE: load/exp writes accepted; writes in any other state ignored; out-of-range load_addr (>80) or exp_idx (>14) ignored.
REQ-022 IDLE->SEND on start; start outside IDLE ignored.
REQ-023 SEND: in_valid=1 for exactly 81 consecutive cycles, first cycle the one after start, in = cell[0..80] in order; in=0 whenever in_valid=0.
REQ-024 SEND counts blanks (4-bit saturating at 15 plus overflow flag); after cell 80 -> WAIT.
REQ-025 WAIT->RECV on first out_valid; word captured in that same cycle.
REQ-026 RECV: consecutive out_valid words compared to exp[k], k from 0; out_valid low after one or more words -> CHECK.
REQ-027 exp_nosol=1: exactly one word of value 10 required; exp_nosol=0: exactly 15 words matching exp[0..14].
REQ-028 Blank count != 15 with exp_nosol=0 -> err 5 set at end of SEND; transaction still runs to CHECK.
REQ-029 Wrong word count (short, or >15 while out_valid stays high) -> err 2; extra words not compared.
REQ-030 out_valid high during SEND -> err 3.
REQ-031 Error priority when several occur: 3 > 5 > 2 > 1 > 4; first-latched highest-priority code kept.
REQ-032 CHECK: one cycle; done=1, pass=(err_code==0); ->IDLE.
REQ-033 busy=1 in SEND, WAIT, RECV, CHECK.
REQ-034 Puzzle/expected storage retained across transactions; start without reload resends same puzzle.

Reset
REQ-035 rst_n low: state IDLE; in_valid, in, busy, done, pass 0; err_code 0; counters 0; cell/expected storage cleared to 0.
REQ-036 Reset mid-transaction aborts immediately; no done pulse produced.

Configuration
REQ-037 SD_TX_TIMEOUT_EN defined: WAIT counter; TIMEOUT_CYC cycles without out_valid -> err 4, ->CHECK.
REQ-038 SD_TX_TIMEOUT_EN undefined: no counter; WAIT indefinitely; err 4 never produced.

Structure
REQ-039 Package sd_pkg: CELLS=81, BLANKS=15, NOSOL_CODE=4'd10, state enum, err_code constants.
REQ-040 Sub-module sd_cell_mem: 81x4 register file, one write port, one sequential-read index.

Verification
REQ-041 Load 81-cell puzzle with 15 zeros, expected 15 values, start -> 81 cells on in in order, solver returns matching 15 -> done, pass=1, err 0.
REQ-042 Same, answer word 7 replaced by value 3 -> pass=0, err 1.
REQ-043 exp_nosol=1, solver returns single 10 -> pass=1; solver returns 15 words -> err 2.
REQ-044 Puzzle with 14 zeros, exp_nosol=0 -> err 5 after full transaction.
REQ-045 out_valid pulsed at SEND cycle 40 -> err 3; with SD_TX_TIMEOUT_EN, TIMEOUT_CYC=50 and no answer -> err 4 at cycle 50 of WAIT.
REQ-046 rst_n low at SEND cycle 30 -> in_valid 0 same cycle, IDLE, no done; next start resends from cell 0 after reload.
